// File: rtl/sdrc_port_arbiter_if.sv
// Bus bundle between the port-side masters, the port arbiter and sdrc_core's
// application interface. The arbiter uses the slave view; the surrounding
// environment (masters plus core) uses the master view.
interface sdrc_port_arbiter_if #(
   parameter int NUM_PORTS = 4,
   parameter int ADDR_W    = 26,
   parameter int LEN_W     = 9,
   parameter int DATA_W    = 32
);
   localparam int BE_W  = DATA_W / 8;
   localparam int OWN_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   // port side
   logic [NUM_PORTS-1:0]        p_req;
   logic [NUM_PORTS*ADDR_W-1:0] p_addr;
   logic [NUM_PORTS*LEN_W-1:0]  p_len;
   logic [NUM_PORTS-1:0]        p_wr_n;
   logic [NUM_PORTS*DATA_W-1:0] p_wr_data;
   logic [NUM_PORTS*BE_W-1:0]   p_wr_en_n;
   logic [NUM_PORTS-1:0]        p_req_ack;
   logic [NUM_PORTS-1:0]        p_wr_next;
   logic [NUM_PORTS-1:0]        p_rd_valid;
   logic [DATA_W-1:0]           p_rd_data;
   logic [NUM_PORTS-1:0]        p_abort;

   // core side
   logic                        app_req;
   logic [ADDR_W-1:0]           app_req_addr;
   logic [LEN_W-1:0]            app_req_len;
   logic                        app_req_wr_n;
   logic                        app_req_ack;
   logic [DATA_W-1:0]           app_wr_data;
   logic [BE_W-1:0]             app_wr_en_n;
   logic                        app_wr_next;
   logic                        app_last_wr;
   logic                        app_rd_valid;
   logic                        app_last_rd;
   logic [DATA_W-1:0]           app_rd_data;

   // status
   logic [OWN_W-1:0]            owner;

   modport slave (
      input  p_req, p_addr, p_len, p_wr_n, p_wr_data, p_wr_en_n,
      input  app_req_ack, app_wr_next, app_last_wr, app_rd_valid, app_last_rd, app_rd_data,
      output p_req_ack, p_wr_next, p_rd_valid, p_rd_data, p_abort,
      output app_req, app_req_addr, app_req_len, app_req_wr_n, app_wr_data, app_wr_en_n,
      output owner
   );

   modport master (
      output p_req, p_addr, p_len, p_wr_n, p_wr_data, p_wr_en_n,
      output app_req_ack, app_wr_next, app_last_wr, app_rd_valid, app_last_rd, app_rd_data,
      input  p_req_ack, p_wr_next, p_rd_valid, p_rd_data, p_abort,
      input  app_req, app_req_addr, app_req_len, app_req_wr_n, app_wr_data, app_wr_en_n,
      input  owner
   );
endinterface

// File: rtl/sdrc_port_arbiter.sv
// Round-robin arbiter sharing the sdrc_core application interface among
// NUM_PORTS requesters. One burst at a time: the grant is held from request
// issue until the last data beat (or a DATA-phase timeout), then rotates.
module sdrc_port_arbiter #(
   parameter int NUM_PORTS = 4,
   parameter int ADDR_W    = 26,
   parameter int LEN_W     = 9,
   parameter int DATA_W    = 32,
   parameter int TIMEOUT   = 1024
) (
   input  logic               sdram_clk,
   input  logic               sdram_resetn,
   sdrc_port_arbiter_if.slave bus
);
   localparam int BE_W  = DATA_W / 8;
   localparam int OWN_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam bit TMO_EN = (TIMEOUT > 0);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   logic [1:0]           state_r;
   logic [OWN_W-1:0]     rr_ptr_r;
   logic [OWN_W-1:0]     owner_r;
   logic                 app_req_r;
   logic [ADDR_W-1:0]    addr_r;
   logic [LEN_W-1:0]     len_r;
   logic                 wr_n_r;
   logic [TMO_W-1:0]     tmo_cnt_r;

   logic                 grant_found_s;
   logic [OWN_W-1:0]     grant_s;
   logic [ADDR_W-1:0]    sel_addr_s;
   logic [LEN_W-1:0]     sel_len_s;
   logic                 sel_wr_n_s;
   logic [DATA_W-1:0]    own_wr_data_s;
   logic [BE_W-1:0]      own_wr_en_n_s;
   logic [NUM_PORTS-1:0] owner_oh_s;
   logic                 in_req_s;
   logic                 in_data_s;
   logic                 wr_beat_s;
   logic                 rd_beat_s;
   logic                 last_s;
   logic                 tmo_hit_s;
   logic [OWN_W-1:0]     next_ptr_s;

   // Round-robin search: first requesting port starting at rr_ptr, wrapping.
   always_comb begin
      grant_found_s = 1'b0;
      grant_s       = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         int  idx;
         logic hit;
         idx           = (int'(rr_ptr_r) + i) % NUM_PORTS;
         hit           = !grant_found_s && bus.p_req[idx];
         grant_s       = hit ? OWN_W'(idx) : grant_s;
         grant_found_s = grant_found_s | hit;
      end
   end

   // Field muxes: request fields of the port being granted, data of the current owner.
   always_comb begin
      sel_addr_s    = '0;
      sel_len_s     = '0;
      sel_wr_n_s    = 1'b1;
      own_wr_data_s = '0;
      own_wr_en_n_s = '1;
      for (int i = 0; i < NUM_PORTS; i++) begin
         sel_addr_s    = (grant_s == OWN_W'(i)) ? bus.p_addr[i*ADDR_W +: ADDR_W] : sel_addr_s;
         sel_len_s     = (grant_s == OWN_W'(i)) ? bus.p_len[i*LEN_W +: LEN_W]    : sel_len_s;
         sel_wr_n_s    = (grant_s == OWN_W'(i)) ? bus.p_wr_n[i]                  : sel_wr_n_s;
         own_wr_data_s = (owner_r == OWN_W'(i)) ? bus.p_wr_data[i*DATA_W +: DATA_W] : own_wr_data_s;
         own_wr_en_n_s = (owner_r == OWN_W'(i)) ? bus.p_wr_en_n[i*BE_W +: BE_W]     : own_wr_en_n_s;
      end
   end

   // Beat qualification, burst termination and timeout detection.
   always_comb begin
      owner_oh_s = NUM_PORTS'(1) << owner_r;
      in_req_s   = (state_r == ST_REQ);
      in_data_s  = (state_r == ST_DATA);
      // beats in the direction opposite to the burst are not routed
      wr_beat_s  = in_data_s && !wr_n_r && bus.app_wr_next;
      rd_beat_s  = in_data_s &&  wr_n_r && bus.app_rd_valid;
      last_s     = (wr_beat_s && bus.app_last_wr) || (rd_beat_s && bus.app_last_rd);
      // a last beat in the final allowed cycle wins over the abort
      tmo_hit_s  = TMO_EN && in_data_s && !last_s && (tmo_cnt_r == TMO_LAST);
      next_ptr_s = (owner_r == OWN_W'(NUM_PORTS - 1)) ? '0 : (owner_r + OWN_W'(1));
   end

   // Arbitration FSM and registered request fields.
   always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
      if (!sdram_resetn) begin
         state_r   <= ST_IDLE;
         rr_ptr_r  <= '0;
         owner_r   <= '0;
         app_req_r <= 1'b0;
         addr_r    <= '0;
         len_r     <= '0;
         wr_n_r    <= 1'b1;
         tmo_cnt_r <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (grant_found_s) begin
                  owner_r   <= grant_s;
                  addr_r    <= sel_addr_s;
                  len_r     <= sel_len_s;
                  wr_n_r    <= sel_wr_n_s;
                  app_req_r <= 1'b1;
                  state_r   <= ST_REQ;
               end else begin
                  app_req_r <= 1'b0;
               end
            end
            ST_REQ: begin
               if (bus.app_req_ack) begin
                  app_req_r <= 1'b0;
                  tmo_cnt_r <= '0;
                  state_r   <= ST_DATA;
               end else begin
                  app_req_r <= 1'b1;
               end
            end
            ST_DATA: begin
               if (last_s || tmo_hit_s) begin
                  rr_ptr_r <= next_ptr_s;
                  state_r  <= ST_IDLE;
               end else begin
                  tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
               end
            end
            default: begin
               app_req_r <= 1'b0;
               state_r   <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.app_req      = app_req_r;
   assign bus.app_req_addr = addr_r;
   assign bus.app_req_len  = len_r;
   assign bus.app_req_wr_n = wr_n_r;
   assign bus.app_wr_data  = own_wr_data_s;
   assign bus.app_wr_en_n  = own_wr_en_n_s;
   assign bus.owner        = owner_r;
   assign bus.p_rd_data    = bus.app_rd_data;
   assign bus.p_req_ack    = (in_req_s && bus.app_req_ack) ? owner_oh_s : '0;
   assign bus.p_wr_next    = wr_beat_s ? owner_oh_s : '0;
   assign bus.p_rd_valid   = rd_beat_s ? owner_oh_s : '0;
   assign bus.p_abort      = tmo_hit_s ? owner_oh_s : '0;
endmodule
